uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter that serialises one parallel byte per request into a standard asynchronous frame: start bit, data LSB-first, optional parity, and one stop bit. It pairs with the UART receiver on the opposite end of the serial link and shares the same 16x-oversampled baud tick generator. Each bit is held for OVERSAMPLE baud ticks.

## Interface
- DATA_WIDTH, 8: data bits per frame.
- OVERSAMPLE, 16: baud ticks per bit. Must be ≥2; the tick counter is $clog2(OVERSAMPLE) bits wide.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when parity is compiled out.
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-clock pulse, OVERSAMPLE per bit period.
- tx_start  input  1  request to send tx_data. Sampled only when tx_busy=0.
- tx_data  input  DATA_WIDTH  byte to send. Latched on the cycle tx_start is accepted.
- tx_serial  output  1  serial line, registered. Idles high.
- tx_busy  output  1  registered. High from the cycle after acceptance until the end of the stop bit.
- tx_done  output  1  registered. One-cycle pulse when the stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_serial=1.
  - On tx_start=1, latch tx_data into the shift register, clear the tick and bit counters, and go to START.
- START: tx_serial=0.
- DATA:
  - tx_serial = shift_reg[0].
  - At each bit end, shift right and increment the bit counter.
  - After bit DATA_WIDTH-1 ends, go to PARITY, or to STOP if parity is compiled out.
- PARITY: tx_serial = XOR of latched data, inverted when PARITY_ODD=1.
- STOP:
  - tx_serial=1.
  - At bit end, go to IDLE and pulse tx_done.
- Bit end occurs on a cycle with baud_tick=1 and tick_cnt==OVERSAMPLE-1:
  - tick_cnt wraps to 0 and the state advances.
  - Otherwise, baud_tick=1 increments tick_cnt, and baud_tick=0 holds it.
- Parity is computed from the latched copy of tx_data, never the live input.
- tx_start while tx_busy=1 is ignored: no queueing, no error. tx_data changes while busy have no effect.
- Reset:
  - tx_serial=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0, shift register 0.
  - Reset mid-frame abandons the frame. The line is high on the cycle after the reset edge, and no tx_done is produced.

## Timing
- Acceptance edge = cycle 0. tx_serial falls and tx_busy rises at cycle 1.
- With baud_tick stuck high, each bit occupies exactly OVERSAMPLE cycles.
- Start bit occupies cycles 1..16 at defaults.
- Frame length is (2 + DATA_WIDTH + P) × OVERSAMPLE ticks, where P=1 with parity and 0 without. At defaults: 176 ticks with parity, 160 without.
- On the edge ending the stop bit, tx_busy→0 and tx_done→1 together. tx_done lasts exactly one cycle.
- Back-to-back frames:
  - tx_start is accepted in the same cycle tx_done=1, because tx_busy=0 then.
  - The next start bit begins the following cycle, with no extra idle bit.
- baud_tick is not aligned to acceptance. The first bit lasts OVERSAMPLE ticks counted from the first tick after acceptance.
- A baud_tick on the acceptance cycle itself is not counted.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state is present, frames carry a parity bit, and PARITY_ODD selects the sense.
  - Undefined: the PARITY state and parity logic are absent, DATA goes directly to STOP, and the frame is DATA_WIDTH+2 bits.
- Frame format must match the receiver's parity configuration.

## Test plan
- Reset: assert reset for 3 cycles with tx_start=1 → tx_serial=1, tx_busy=0, tx_done=0 throughout. No frame starts until the cycle after reset deasserts.
- Even parity, baud_tick every cycle, tx_data=0xA5:
  - tx_serial sequence per 16-cycle bit: 0,1,0,1,0,0,1,0,1,0(parity),1.
  - tx_busy high for cycles 1..176; tx_done=1 at cycle 177 only.
- Odd parity (PARITY_ODD=1), tx_data=0x01 → parity bit 0. Same data with even parity → parity bit 1.
- Sparse tick, baud_tick every 4th cycle, tx_data=0x00 → each bit is 64 cycles wide. The line stays low for 9 bits (start + 8 data), then parity 0, then stop 1.
- Busy and back-to-back:
  - tx_start pulses mid-frame with tx_data=0xFF → ignored, and the frame in progress is unchanged.
  - tx_start=1 with tx_data=0x3C in the tx_done cycle → a new start bit on the next cycle.
- Reset mid-frame during DATA bit 3 → tx_serial=1 on the next cycle, no tx_done. A new tx_start afterwards produces a clean full frame.
- Build without UART_TX_PARITY_EN, tx_data=0xA5 → 160-cycle frame with the stop bit directly after bit 7.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter.
// Frame is a start bit, DATA_WIDTH data bits sent LSB first, an optional
// parity bit and one stop bit. Each bit is held for OVERSAMPLE baud ticks.
// Build option: define UART_TX_PARITY_EN to include the parity bit
// (PARITY_ODD selects its sense); without it the frame is DATA_WIDTH+2 bits.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  serial_q, serial_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;

`ifdef UART_TX_PARITY_EN
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  parity_bit;

  // Parity from the latched copy so the live input can change freely.
  always_comb begin
    parity_bit = (^data_q) ^ (PARITY_ODD != 0);
  end
`endif

  // Next-state, counters and registered line value (line follows next state).
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    serial_d = 1'b1;
`ifdef UART_TX_PARITY_EN
    data_d   = data_q;
`endif
    bit_end  = baud_tick && (tick_q == TW'(OVERSAMPLE - 1));

    if (state_q == S_IDLE) begin
      if (tx_start) begin
        shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
        data_d  = tx_data;
`endif
        tick_d  = '0;
        bit_d   = '0;
        state_d = S_START;
      end
    end else begin
      if (bit_end) begin
        tick_d = '0;
      end else if (baud_tick) begin
        tick_d = tick_q + 1'b1;
      end
    end

    case (state_q)
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: serial_d = parity_bit;
`endif
      default:  serial_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      data_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      data_q   <= data_d;
`endif
    end
  end

  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx (even and odd parity instances
// driven in parallel). Follows UART_TX_PARITY_EN for the expected frame.
module tb_uart_tx;

  localparam int unsigned OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ser_e, busy_e, done_e;
  logic       ser_o, busy_o, done_o;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut_even (
    .clock(clk), .reset(reset), .baud_tick(baud_tick), .tx_start(tx_start),
    .tx_data(tx_data), .tx_serial(ser_e), .tx_busy(busy_e), .tx_done(done_e)
  );

  uart_tx #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_ODD(1)) dut_odd (
    .clock(clk), .reset(reset), .baud_tick(baud_tick), .tx_start(tx_start),
    .tx_data(tx_data), .tx_serial(ser_o), .tx_busy(busy_o), .tx_done(done_o)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected line value for bit slot idx of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int unsigned idx, input bit odd);
    logic [7:0] v;
    v = d;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return v[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return (^v) ^ odd;
`endif
    return 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " ser_e"}, ser_e, 1'b1);
    check({tag, " busy_e"}, busy_e, 1'b0);
    check({tag, " done_e"}, done_e, 1'b0);
    check({tag, " ser_o"}, ser_o, 1'b1);
    check({tag, " busy_o"}, busy_o, 1'b0);
    check({tag, " done_o"}, done_o, 1'b0);
  endtask

  // Starts and ends just after a negedge.
  task automatic idle(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tx_start = 1'b0;
      baud_tick = 1'b1;
      @(negedge clk);
      check_idle($sformatf("%s i%0d", tag, i));
    end
  endtask

  // Requests one frame in the current cycle and follows it to the done cycle.
  // period: baud_tick every period cycles; poke: mid-frame tx_start with 0xFF;
  // abort_at: nonzero cycle at which reset is pulsed.
  task automatic frame(input logic [7:0] data, input int unsigned period, input bit poke,
                       input int unsigned abort_at, input string tag);
    int unsigned ticks;
    int unsigned idx;
    ticks = 0;
    tx_start = 1'b1;
    tx_data = data;
    baud_tick = (period == 1);
    @(posedge clk); #1;
    for (int unsigned c = 1; c < 4000; c++) begin
      tx_start = 1'b0;
      baud_tick = ((c % period) == (period - 1));
      if (poke && c == 40) begin
        tx_start = 1'b1;
        tx_data = 8'hFF;
      end
      if (abort_at != 0 && c == abort_at) reset = 1'b1;
      idx = ticks / OS;
      @(negedge clk);
      if (idx < NB) begin
        check($sformatf("%s c%0d ser_e", tag, c), ser_e, exp_bit(data, idx, 1'b0));
        check($sformatf("%s c%0d ser_o", tag, c), ser_o, exp_bit(data, idx, 1'b1));
        check($sformatf("%s c%0d busy_e", tag, c), busy_e, 1'b1);
        check($sformatf("%s c%0d busy_o", tag, c), busy_o, 1'b1);
        check($sformatf("%s c%0d done_e", tag, c), done_e, 1'b0);
        check($sformatf("%s c%0d done_o", tag, c), done_o, 1'b0);
      end else begin
        check($sformatf("%s c%0d ser_e", tag, c), ser_e, 1'b1);
        check($sformatf("%s c%0d ser_o", tag, c), ser_o, 1'b1);
        check($sformatf("%s c%0d busy_e", tag, c), busy_e, 1'b0);
        check($sformatf("%s c%0d busy_o", tag, c), busy_o, 1'b0);
        check($sformatf("%s c%0d done_e", tag, c), done_e, 1'b1);
        check($sformatf("%s c%0d done_o", tag, c), done_o, 1'b1);
        return;
      end
      if (baud_tick) ticks++;
      if (abort_at != 0 && c == abort_at) begin
        @(posedge clk); #1;
        reset = 1'b0;
        tx_start = 1'b0;
        baud_tick = 1'b1;
        @(negedge clk);
        check_idle($sformatf("%s post-reset", tag));
        idle(NB * OS + 20, {tag, " quiet"});
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    tx_start = 1'b1;
    tx_data = 8'h5A;
    baud_tick = 1'b1;
    // Reset held three cycles with tx_start asserted.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_idle($sformatf("reset r%0d", i));
    end
    reset = 1'b0;
    tx_start = 1'b0;
    idle(3, "after_reset");

    // Dense ticks, including a tick on the acceptance cycle.
    frame(8'hA5, 1, 1'b0, 0, "a5");
    idle(2, "a5_tail");
    frame(8'h01, 1, 1'b0, 0, "x01");
    idle(1, "x01_tail");

    // Sparse ticks: 64-cycle bits.
    frame(8'h00, 4, 1'b0, 0, "sparse");
    idle(1, "sparse_tail");

    // Mid-frame request ignored, then back-to-back start in the done cycle.
    frame(8'h5A, 1, 1'b1, 0, "busy");
    frame(8'h3C, 1, 1'b0, 0, "b2b");
    idle(2, "b2b_tail");

    // Reset during data bit 3 (bit slot 4 spans cycles 65..80).
    frame(8'hA5, 1, 1'b0, 70, "abort");
    frame(8'h96, 1, 1'b0, 0, "reframe");
    idle(2, "end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
